gen_aludata_fwd: RTL and testbench

- Next-generation ALU operand generator for the pipelined RISC-V core, sitting at the ID/EX boundary.
- Selects op1/op2 from register, immediate, PC or zero, with operand forwarding from NUM_FWD later pipeline stages.
- Detects load-use hazards and stalls.
- Registers the result into a valid/ready EX-input stage with flush, plus a saturating stall counter.

---
 rtl/gen_aludata_fwd_pkg.sv | 16 +
 rtl/gen_aludata_fwd_if.sv | 47 ++++
 rtl/gen_aludata_fwd_fwd_select.sv | 32 +++
 rtl/gen_aludata_fwd.sv | 120 ++++++++++++
 tb/tb_gen_aludata_fwd.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_aludata_fwd_pkg.sv
// Shared constants for the ALU operand generator:
// operand source encodings, register index width, default widths.
package gen_aludata_fwd_pkg;

    typedef enum logic [1:0] {
        OP_TYPE_REG  = 2'b00,
        OP_TYPE_IMM  = 2'b01,
        OP_TYPE_PC   = 2'b10,
        OP_TYPE_ZERO = 2'b11
    } op_type_e;

    localparam int REG_W    = 5;
    localparam int XLEN_DEF = 32;
    localparam int PC_W_DEF = 17;

endpackage

// File: rtl/gen_aludata_fwd_if.sv
// ID->EX operand bundle: ID request, forwarding sources, EX-side result.
// master = ID/forwarding side, slave = operand generator.
interface gen_aludata_fwd_if
    import gen_aludata_fwd_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          imm;
    logic [1:0]               aluop1_type;
    logic [1:0]               aluop2_type;
    logic [PC_W-1:0]          pc;
    logic [REG_W-1:0]         rs1;
    logic [REG_W-1:0]         rs2;
    logic [XLEN-1:0]          reg_data1;
    logic [XLEN-1:0]          reg_data2;
    logic [NUM_FWD-1:0]       fwd_valid;
    logic [NUM_FWD*REG_W-1:0] fwd_rd;
    logic [NUM_FWD-1:0]       fwd_busy;
    logic [NUM_FWD*XLEN-1:0]  fwd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          op1;
    logic [XLEN-1:0]          op2;
    logic [XLEN-1:0]          store_data;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output flush, in_valid, imm, aluop1_type, aluop2_type, pc,
        output rs1, rs2, reg_data1, reg_data2,
        output fwd_valid, fwd_rd, fwd_busy, fwd_data, out_ready,
        input  in_ready, out_valid, op1, op2, store_data, stall_cnt
    );

    modport slave (
        input  flush, in_valid, imm, aluop1_type, aluop2_type, pc,
        input  rs1, rs2, reg_data1, reg_data2,
        input  fwd_valid, fwd_rd, fwd_busy, fwd_data, out_ready,
        output in_ready, out_valid, op1, op2, store_data, stall_cnt
    );

endinterface

// File: rtl/gen_aludata_fwd_fwd_select.sv
// Priority forwarding match for one source register (index 0 youngest).
// Ports: rs_i/reg_data_i, packed fwd_* sources -> data_o, busy_o.
module gen_aludata_fwd_fwd_select
    import gen_aludata_fwd_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_FWD = 2
) (
    input  logic [REG_W-1:0]         rs_i,
    input  logic [XLEN-1:0]          reg_data_i,
    input  logic [NUM_FWD-1:0]       fwd_valid_i,
    input  logic [NUM_FWD*REG_W-1:0] fwd_rd_i,
    input  logic [NUM_FWD-1:0]       fwd_busy_i,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data_i,
    output logic [XLEN-1:0]          data_o,
    output logic                     busy_o
);

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        data_o = reg_data_i;
        busy_o = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (rs_i != '0 && fwd_valid_i[i] &&
                fwd_rd_i[i*REG_W +: REG_W] == rs_i) begin
                data_o = fwd_data_i[i*XLEN +: XLEN];
                busy_o = fwd_busy_i[i];
            end
        end
    end

endmodule

// File: rtl/gen_aludata_fwd.sv
// ALU operand generator with forwarding, load-use stall and EX register.
// Ports: clk, rst_n (async, active-low), bus (slave side of the bundle).
module gen_aludata_fwd
    import gen_aludata_fwd_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    gen_aludata_fwd_if.slave   bus
);

    logic [XLEN-1:0]  fwd1, fwd2, pc_ext;
    logic [XLEN-1:0]  sel1, sel2;
    logic             busy1, busy2;
    logic             hazard, cap;

    logic             vld_q, vld_d;
    logic [XLEN-1:0]  op1_q, op1_d;
    logic [XLEN-1:0]  op2_q, op2_d;
    logic [XLEN-1:0]  sd_q, sd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    gen_aludata_fwd_fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel1 (
        .rs_i        (bus.rs1),
        .reg_data_i  (bus.reg_data1),
        .fwd_valid_i (bus.fwd_valid),
        .fwd_rd_i    (bus.fwd_rd),
        .fwd_busy_i  (bus.fwd_busy),
        .fwd_data_i  (bus.fwd_data),
        .data_o      (fwd1),
        .busy_o      (busy1)
    );

    gen_aludata_fwd_fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel2 (
        .rs_i        (bus.rs2),
        .reg_data_i  (bus.reg_data2),
        .fwd_valid_i (bus.fwd_valid),
        .fwd_rd_i    (bus.fwd_rd),
        .fwd_busy_i  (bus.fwd_busy),
        .fwd_data_i  (bus.fwd_data),
        .data_o      (fwd2),
        .busy_o      (busy2)
    );

    function automatic logic [XLEN-1:0] pick(
        input logic [1:0]      t,
        input logic [XLEN-1:0] r,
        input logic [XLEN-1:0] i,
        input logic [XLEN-1:0] p
    );
        logic [XLEN-1:0] v;
        v = '0;
        unique case (1'b1)
            (t == OP_TYPE_REG): v = r;
            (t == OP_TYPE_IMM): v = i;
            (t == OP_TYPE_PC):  v = p;
            default:            v = '0;
        endcase
        return v;
    endfunction

    assign pc_ext = XLEN'(bus.pc);
    assign sel1   = pick(bus.aluop1_type, fwd1, bus.imm, pc_ext);
    assign sel2   = pick(bus.aluop2_type, fwd2, bus.imm, pc_ext);

    // rs2 is always checked since store_data may need it regardless of op2.
    assign hazard = bus.in_valid &&
                    ((bus.aluop1_type == OP_TYPE_REG && busy1) || busy2);

    assign bus.in_ready = !hazard && (!vld_q || bus.out_ready);
    assign cap          = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        vld_d = vld_q;
        op1_d = op1_q;
        op2_d = op2_q;
        sd_d  = sd_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            vld_d = 1'b0;
        end else if (cap) begin
            vld_d = 1'b1;
            op1_d = sel1;
            op2_d = sel2;
            sd_d  = fwd2;
        end else if (vld_q && bus.out_ready) begin
            vld_d = 1'b0;
        end
        if (hazard && !bus.flush && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            op1_q <= '0;
            op2_q <= '0;
            sd_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            sd_q  <= sd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.op1        = op1_q;
    assign bus.op2        = op2_q;
    assign bus.store_data = sd_q;
    assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_gen_aludata_fwd.sv
// Directed bench for gen_aludata_fwd: vector table plus stall,
// back-pressure, flush, saturation and async-reset sequences.
module tb_gen_aludata_fwd;

    localparam logic [1:0] T_REG  = 2'b00;
    localparam logic [1:0] T_IMM  = 2'b01;
    localparam logic [1:0] T_PC   = 2'b10;
    localparam logic [1:0] T_ZERO = 2'b11;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gen_aludata_fwd_if #(
        .XLEN(32), .PC_W(17), .NUM_FWD(2), .CNT_W(4)
    ) bus ();

    gen_aludata_fwd #(
        .XLEN(32), .PC_W(17), .NUM_FWD(2), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t1;
        logic [1:0]  t2;
        logic [16:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [1:0]  fv;
        logic [9:0]  frd;
        logic [1:0]  fb;
        logic [63:0] fd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] esd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.aluop1_type = v.t1;
        bus.aluop2_type = v.t2;
        bus.pc          = v.pc;
        bus.imm         = v.imm;
        bus.rs1         = v.rs1;
        bus.rs2         = v.rs2;
        bus.reg_data1   = v.rd1;
        bus.reg_data2   = v.rd2;
        bus.fwd_valid   = v.fv;
        bus.fwd_rd      = v.frd;
        bus.fwd_busy    = v.fb;
        bus.fwd_data    = v.fd;
    endtask

    task automatic clr_fwd();
        bus.fwd_valid = '0;
        bus.fwd_rd    = '0;
        bus.fwd_busy  = '0;
        bus.fwd_data  = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{T_PC, T_IMM, 17'h1_0004, 32'hFFFF_FFF0, 5'd0, 5'd0,
                    32'h1111_1111, 32'h2222_2222, 2'b00, 10'd0, 2'b00,
                    64'd0, 32'h0001_0004, 32'hFFFF_FFF0, 32'h2222_2222};
        vecs[1] = '{T_REG, T_ZERO, 17'h0, 32'h0, 5'd5, 5'd3,
                    32'h1111_1111, 32'h3333_3333, 2'b11, {5'd5, 5'd5},
                    2'b00, {32'hBBBB_BBBB, 32'hAAAA_AAAA},
                    32'hAAAA_AAAA, 32'h0, 32'h3333_3333};
        vecs[2] = '{T_REG, T_REG, 17'h0, 32'h0, 5'd0, 5'd0,
                    32'h0000_CAFE, 32'h1234_5678, 2'b11, {5'd0, 5'd0},
                    2'b00, {32'hBBBB_BBBB, 32'hAAAA_AAAA},
                    32'h0000_CAFE, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{T_REG, T_REG, 17'h0, 32'h0, 5'd9, 5'd9,
                    32'h0, 32'h0, 2'b10, {5'd9, 5'd9},
                    2'b00, {32'hBBBB_BBBB, 32'hAAAA_AAAA},
                    32'hBBBB_BBBB, 32'hBBBB_BBBB, 32'hBBBB_BBBB};
        vecs[4] = '{T_REG, T_IMM, 17'h0, 32'h7, 5'd4, 5'd4,
                    32'h0, 32'h0, 2'b11, {5'd4, 5'd4},
                    2'b10, {32'hBBBB_BBBB, 32'hAAAA_AAAA},
                    32'hAAAA_AAAA, 32'h7, 32'hAAAA_AAAA};
        vecs[5] = '{T_ZERO, T_PC, 17'h1_FFFF, 32'h0, 5'd0, 5'd6,
                    32'h0, 32'h6666_6666, 2'b01, {5'd0, 5'd6},
                    2'b00, {32'h0, 32'h5555_5555},
                    32'h0, 32'h0001_FFFF, 32'h5555_5555};
        vecs[6] = '{T_IMM, T_ZERO, 17'h0, 32'h42, 5'd8, 5'd0,
                    32'h0, 32'h0000_0099, 2'b01, {5'd0, 5'd8},
                    2'b01, {32'h0, 32'h8888_8888},
                    32'h42, 32'h0, 32'h0000_0099};

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        clr_fwd();
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_op1", bus.op1, 32'd0);
        chk("rst_op2", bus.op2, 32'd0);
        chk("rst_store_data", bus.store_data, 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Table: each vector accepted and captured with one-cycle latency.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i]);
            bus.in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            tick();
            chk($sformatf("vec%0d_out_valid", i),
                32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_op1", i), bus.op1, vecs[i].e1);
            chk($sformatf("vec%0d_op2", i), bus.op2, vecs[i].e2);
            chk($sformatf("vec%0d_store", i), bus.store_data, vecs[i].esd);
        end
        chk("vec_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // Load-use stall on rs1 for three cycles.
        bus.aluop1_type = T_REG;
        bus.aluop2_type = T_IMM;
        bus.imm         = 32'h77;
        bus.rs1         = 5'd7;
        bus.rs2         = 5'd0;
        bus.reg_data2   = 32'h0;
        bus.fwd_valid   = 2'b01;
        bus.fwd_rd      = {5'd0, 5'd7};
        bus.fwd_busy    = 2'b01;
        bus.fwd_data    = 64'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i),
                32'(bus.in_ready), 32'd0);
            tick();
        end
        chk("stall_cnt_3", 32'(bus.stall_cnt), 32'd3);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd0);
        bus.fwd_busy = 2'b00;
        bus.fwd_data = {32'h0, 32'h0000_1234};
        #1;
        chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("unstall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("unstall_op1", bus.op1, 32'h0000_1234);
        chk("unstall_stall_cnt", 32'(bus.stall_cnt), 32'd3);

        // Back-pressure: EX not ready, stage holds for four cycles.
        clr_fwd();
        bus.out_ready   = 1'b0;
        bus.aluop1_type = T_IMM;
        bus.imm         = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d_op1", i), bus.op1, 32'h0000_1234);
            chk($sformatf("bp%0d_op2", i), bus.op2, 32'h77);
            chk($sformatf("bp%0d_out_valid", i),
                32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_release_op1", bus.op1, 32'hDEAD_BEEF);
        chk("bp_release_op2", bus.op2, 32'hDEAD_BEEF);

        // Flush with an accepted input: no capture, valid drops.
        bus.imm   = 32'h0BAD_0BAD;
        bus.flush = 1'b1;
        tick();
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_op1", bus.op1, 32'hDEAD_BEEF);
        chk("flush_stall_cnt", 32'(bus.stall_cnt), 32'd3);
        // Flush also suppresses stall counting.
        bus.aluop1_type = T_REG;
        bus.fwd_valid   = 2'b01;
        bus.fwd_rd      = {5'd0, 5'd7};
        bus.fwd_busy    = 2'b01;
        tick();
        chk("flush_hazard_cnt", 32'(bus.stall_cnt), 32'd3);
        chk("flush_hazard_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'hF);
        chk("sat_in_ready", 32'(bus.in_ready), 32'd0);

        // Async reset mid-transfer with a stall pending.
        clr_fwd();
        bus.aluop1_type = T_IMM;
        bus.imm         = 32'h600D;
        bus.rs2         = 5'd0;
        bus.reg_data2   = 32'h99;
        tick();
        chk("pre_rst_op1", bus.op1, 32'h600D);
        chk("pre_rst_store", bus.store_data, 32'h99);
        bus.out_ready   = 1'b0;
        bus.aluop1_type = T_REG;
        bus.fwd_valid   = 2'b01;
        bus.fwd_rd      = {5'd0, 5'd7};
        bus.fwd_busy    = 2'b01;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_op1", bus.op1, 32'd0);
        chk("arst_op2", bus.op2, 32'd0);
        chk("arst_store", bus.store_data, 32'd0);
        chk("arst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("arst_in_ready_hz", 32'(bus.in_ready), 32'd0);
        bus.fwd_busy = 2'b00;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("arst_hold_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
